// File: rtl/bubble_pool_ctrl_if.sv
// Signal bundle between the bubble pool controller, the bubble instances and the game top level.
// The slave side is the controller; the master side is whoever drives frames, arrows and bubbles.
interface bubble_pool_ctrl_if #(
    parameter int N       = 7,
    parameter int SCORE_W = 16
);
    logic                 startOfFrame;
    logic                 start;
    logic                 arrowHit;
    logic [N-1:0]         slotDrawReq;
    logic [N*8-1:0]       slotRGB;
    logic [N-1:0]         spawn;
    logic [N-1:0]         hit;
    logic [N-1:0]         alive;
    logic                 drawingRequest;
    logic [7:0]           RGBout;
    logic [5:0]           remaining;
    logic [SCORE_W-1:0]   score;
    logic                 win;

    modport slave (
        input  startOfFrame, start, arrowHit, slotDrawReq, slotRGB,
        output spawn, hit, alive, drawingRequest, RGBout, remaining, score, win
    );

    modport master (
        output startOfFrame, start, arrowHit, slotDrawReq, slotRGB,
        input  spawn, hit, alive, drawingRequest, RGBout, remaining, score, win
    );
endinterface

// File: rtl/bubble_pool_ctrl.sv
// Controller for a heap-ordered split tree of bubbles: tracks live slots, arbitrates arrow hits
// with a frame-based lockout, spawns children on a pop, muxes pixels and keeps score / win.
module bubble_pool_ctrl #(
    parameter int          LEVELS         = 3,
    parameter int          HOLDOFF_FRAMES = 2,
    parameter int          SCORE_BASE     = 10,
    parameter int          SCORE_W        = 16,
    parameter logic [7:0]  TRANSPARENT    = 8'hFF
) (
    input  logic              clk,
    input  logic              resetN,
    bubble_pool_ctrl_if.slave bus
);
    localparam int N      = (1 << LEVELS) - 1;
    localparam int IDX_W  = LEVELS;
    localparam int HOLD_W = $clog2(HOLDOFF_FRAMES + 2);
    localparam int SUM_W  = SCORE_W + 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, LOCKOUT, WON} stateT;

    stateT               state, stateNext;
    logic [HOLD_W-1:0]   holdCnt;
    logic [N-1:0]        spawnQ, hitQ, aliveQ;
    logic [SCORE_W-1:0]  scoreQ, scoreNext;
    logic [5:0]          remainingQ;

    logic                found;
    logic [IDX_W-1:0]    selIdx;
    logic [2:0]          selLvl;
    logic [7:0]          selRGB;
    logic [N-1:0]        hitMask, childMask;
    logic [SUM_W-1:0]    scoreInc, scoreSum;
    logic                doLaunch, doHit;

    // Heap level of a slot: position of the highest set bit of (idx+1)
    function automatic logic [2:0] slotLevel(input int idx);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int j = 1; j < 6; j++) begin
            if (((idx + 1) >> j) != 0) lvl = 3'(j);
        end
        return lvl;
    endfunction

    // Lowest-index alive drawing slot; shared by the pixel mux and hit arbitration
    always_comb begin
        found  = 1'b0;
        selIdx = '0;
        selLvl = '0;
        selRGB = TRANSPARENT;
        for (int i = N - 1; i >= 0; i--) begin
            if (aliveQ[i] && bus.slotDrawReq[i]) begin
                found  = 1'b1;
                selIdx = IDX_W'(i);
                selLvl = slotLevel(i);
                selRGB = bus.slotRGB[8*i +: 8];
            end
        end
    end

    always_comb begin
        hitMask   = '0;
        childMask = '0;
        for (int i = 0; i < N; i++) begin
            hitMask[i] = found && (selIdx == IDX_W'(i));
        end
        for (int c = 1; c < N; c++) begin
            childMask[c] = found && (selIdx == IDX_W'((c - 1) / 2));
        end
    end

    always_comb begin
        scoreInc  = SUM_W'(SCORE_BASE) << selLvl;
        scoreSum  = SUM_W'(scoreQ) + scoreInc;
        scoreNext = (scoreSum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : scoreSum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= stateNext;
    end

    // The last pop goes straight to WON so win and remaining==0 appear together
    always_comb begin
        stateNext = state;
        doLaunch  = 1'b0;
        doHit     = 1'b0;
        case (state)
            IDLE, WON: begin
                if (bus.start) begin
                    doLaunch  = 1'b1;
                    stateNext = ARMED;
                end
            end
            ARMED: begin
                if (bus.arrowHit && found) begin
                    doHit     = 1'b1;
                    stateNext = (remainingQ == 6'd1) ? WON : LOCKOUT;
                end
            end
            LOCKOUT: begin
                if ((holdCnt == '0) && !bus.arrowHit) stateNext = ARMED;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            spawnQ     <= '0;
            hitQ       <= '0;
            aliveQ     <= '0;
            scoreQ     <= '0;
            remainingQ <= 6'(N);
            holdCnt    <= '0;
        end else begin
            spawnQ <= '0;
            hitQ   <= '0;
            if (doLaunch) begin
                spawnQ     <= N'(1);
                aliveQ     <= N'(1);
                scoreQ     <= '0;
                remainingQ <= 6'(N);
            end else if (doHit) begin
                hitQ       <= hitMask;
                spawnQ     <= childMask;
                aliveQ     <= (aliveQ & ~hitMask) | childMask;
                scoreQ     <= scoreNext;
                remainingQ <= remainingQ - 6'd1;
                holdCnt    <= HOLD_W'(HOLDOFF_FRAMES);
            end else if ((state == LOCKOUT) && bus.startOfFrame && (holdCnt != '0)) begin
                holdCnt <= holdCnt - 1'b1;
            end
        end
    end

    assign bus.spawn          = spawnQ;
    assign bus.hit            = hitQ;
    assign bus.alive          = aliveQ;
    assign bus.score          = scoreQ;
    assign bus.remaining      = remainingQ;
    assign bus.win            = (state == WON);
    assign bus.drawingRequest = found;
    assign bus.RGBout         = selRGB;
endmodule

// File: tb/tb_bubble_pool_ctrl.sv
// Directed plus random stimulus for bubble_pool_ctrl, checked against a slot-array game model.
module tb_bubble_pool_ctrl;
    localparam int LEVELS  = 3;
    localparam int N       = 7;
    localparam int HOLDOFF = 2;
    localparam int BASE    = 10;
    localparam int SW      = 16;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_LOCK  = 2;
    localparam int M_WON   = 3;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bubble_pool_ctrl_if #(.N(N), .SCORE_W(SW)) bus ();

    bubble_pool_ctrl #(
        .LEVELS(LEVELS), .HOLDOFF_FRAMES(HOLDOFF), .SCORE_BASE(BASE),
        .SCORE_W(SW), .TRANSPARENT(8'hFF)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [N-1:0] mAlive, mSpawn, mHit;
    int mScore, mRem, mMode, mHold;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic modelReset();
        mAlive = '0; mSpawn = '0; mHit = '0;
        mScore = 0; mRem = N; mMode = M_IDLE; mHold = 0;
    endtask

    // Game rules: one clock of effect for a start, a pop, or a lockout frame tick
    task automatic modelStep(input bit sof, input bit st, input bit ah, input logic [N-1:0] req);
        int k, lvl;
        mSpawn = '0;
        mHit   = '0;
        if ((mMode == M_IDLE || mMode == M_WON) && st) begin
            mAlive = '0; mAlive[0] = 1'b1; mSpawn[0] = 1'b1;
            mScore = 0; mRem = N; mMode = M_ARMED;
        end else if (mMode == M_ARMED && ah) begin
            k = -1;
            for (int i = 0; i < N; i++) if (k < 0 && mAlive[i] && req[i]) k = i;
            if (k >= 0) begin
                lvl = 0;
                while ((2 ** (lvl + 1)) - 1 <= k) lvl++;
                mHit[k] = 1'b1;
                mAlive[k] = 1'b0;
                mScore = mScore + BASE * (2 ** lvl);
                if (mScore > 2 ** SW - 1) mScore = 2 ** SW - 1;
                mRem--;
                if (2 * k + 1 < N) begin
                    mSpawn[2*k+1] = 1'b1; mSpawn[2*k+2] = 1'b1;
                    mAlive[2*k+1] = 1'b1; mAlive[2*k+2] = 1'b1;
                end
                mMode = (mRem == 0) ? M_WON : M_LOCK;
                mHold = HOLDOFF;
            end
        end else if (mMode == M_LOCK) begin
            if (mHold == 0 && !ah) mMode = M_ARMED;
            else if (sof && mHold > 0) mHold--;
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".spawn"}, 32'(bus.spawn), 32'(mSpawn));
        chk({tag, ".hit"}, 32'(bus.hit), 32'(mHit));
        chk({tag, ".alive"}, 32'(bus.alive), 32'(mAlive));
        chk({tag, ".score"}, 32'(bus.score), 32'(mScore));
        chk({tag, ".remaining"}, 32'(bus.remaining), 32'(mRem));
        chk({tag, ".win"}, 32'(bus.win), 32'(mMode == M_WON));
    endtask

    // Called just after a falling edge: drive, check the pixel mux, clock, check registers
    task automatic applyStimulus(input string tag, input bit sof, input bit st, input bit ah,
                                 input logic [N-1:0] req);
        logic [N*8-1:0] rgb;
        logic           expDraw;
        logic [7:0]     expRgb;
        for (int i = 0; i < N; i++) rgb[8*i +: 8] = 8'($urandom);
        bus.startOfFrame = sof;
        bus.start        = st;
        bus.arrowHit     = ah;
        bus.slotDrawReq  = req;
        bus.slotRGB      = rgb;
        #1;
        expDraw = 1'b0;
        expRgb  = 8'hFF;
        for (int i = 0; i < N; i++) begin
            if (!expDraw && mAlive[i] && req[i]) begin
                expDraw = 1'b1;
                expRgb  = rgb[8*i +: 8];
            end
        end
        chk({tag, ".drawingRequest"}, 32'(bus.drawingRequest), 32'(expDraw));
        chk({tag, ".RGBout"}, 32'(bus.RGBout), 32'(expRgb));
        modelStep(sof, st, ah, req);
        @(posedge clk);
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic unlock();
        for (int i = 0; i < 3; i++) applyStimulus("unlock", 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int hitCount;
        int lowest;
        bus.startOfFrame = 1'b0;
        bus.start        = 1'b0;
        bus.arrowHit     = 1'b0;
        bus.slotDrawReq  = '0;
        bus.slotRGB      = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset");
        resetN = 1'b1;

        applyStimulus("launch", 1'b0, 1'b1, 1'b0, '0);
        applyStimulus("popRoot", 1'b0, 1'b0, 1'b1, 7'b0000001);
        chk("popRoot.scoreConst", 32'(bus.score), 32'd10);
        chk("popRoot.aliveConst", 32'(bus.alive), 32'b0000110);
        chk("popRoot.remainingConst", 32'(bus.remaining), 32'd6);

        unlock();
        applyStimulus("bothDrawing", 1'b0, 1'b0, 1'b1, 7'b0000110);
        chk("bothDrawing.hitConst", 32'(bus.hit), 32'b0000010);

        unlock();
        hitCount = 0;
        for (int f = 0; f < 10; f++) begin
            applyStimulus("holdArrow", 1'b1, 1'b0, 1'b1, 7'b0001000);
            if (bus.hit[3]) hitCount++;
            for (int c = 0; c < 2; c++) begin
                applyStimulus("holdArrow", 1'b0, 1'b0, 1'b1, 7'b0001000);
                if (bus.hit[3]) hitCount++;
            end
        end
        chk("holdArrow.singlePop", 32'(hitCount), 32'd1);
        applyStimulus("release", 1'b0, 1'b0, 1'b0, '0);

        applyStimulus("deadSlot", 1'b0, 1'b0, 1'b1, 7'b0100000);
        chk("deadSlot.hitConst", 32'(bus.hit), 32'd0);

        for (int iter = 0; iter < 20 && mRem > 0; iter++) begin
            unlock();
            lowest = -1;
            for (int i = N - 1; i >= 0; i--) if (mAlive[i]) lowest = i;
            if (lowest >= 0) applyStimulus("popAll", 1'b0, 1'b0, 1'b1, N'(1) << lowest);
        end
        chk("popAll.scoreConst", 32'(bus.score), 32'd210);
        chk("popAll.remainingConst", 32'(bus.remaining), 32'd0);
        chk("popAll.winConst", 32'(bus.win), 32'd1);
        chk("popAll.aliveConst", 32'(bus.alive), 32'd0);

        applyStimulus("restart", 1'b0, 1'b1, 1'b0, '0);
        chk("restart.scoreConst", 32'(bus.score), 32'd0);
        chk("restart.remainingConst", 32'(bus.remaining), 32'd7);
        chk("restart.aliveConst", 32'(bus.alive), 32'd1);
        chk("restart.winConst", 32'(bus.win), 32'd0);

        for (int r = 0; r < 400; r++) begin
            applyStimulus("random", ($urandom_range(3) == 0), ($urandom_range(15) == 0),
                          ($urandom_range(1) == 1), N'($urandom));
        end

        resetN = 1'b0;
        modelReset();
        @(negedge clk);
        resetN = 1'b1;
        applyStimulus("relaunch", 1'b0, 1'b1, 1'b0, '0);
        applyStimulus("lockPop", 1'b0, 1'b0, 1'b1, 7'b0000001);
        #2;
        resetN = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncReset");
        @(negedge clk);
        resetN = 1'b1;
        applyStimulus("noStartHit", 1'b0, 1'b0, 1'b1, 7'b0000001);
        chk("noStartHit.hitConst", 32'(bus.hit), 32'd0);
        applyStimulus("postResetLaunch", 1'b0, 1'b1, 1'b0, '0);
        applyStimulus("postResetPop", 1'b0, 1'b0, 1'b1, 7'b0000001);
        chk("postResetPop.hitConst", 32'(bus.hit), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bubble_pool_ctrl.md
Name: bubble_pool_ctrl

Overview:
- Parametrised controller for a binary split-tree of bubble instances, with 2**LEVELS-1 slots in heap order.
- Slot 0 is the root. Children of slot i are 2i+1 (launched leftward, direction 0) and 2i+2 (launched rightward, direction 1).
- Tracks which slots are alive, arbitrates arrow hits with edge/holdoff lockout, issues spawn and hit pulses to the bubble instances, muxes their pixels, and keeps score, remaining count and win.
- Sits between the bubble instances and the top-level draw mux / game FSM.

Parameters:
- LEVELS, 3, number of split levels (1..5); N = 2**LEVELS-1 slots (localparam).
- HOLDOFF_FRAMES, 2, minimum startOfFrame pulses after a hit before another hit is accepted.
- SCORE_BASE, 10, points for popping a level-0 bubble; a level-L pop scores SCORE_BASE<<L.
- SCORE_W, 16, score width.
- TRANSPARENT, 8'hFF, RGBout value when nothing is drawn.

Ports:
- clk  in  1  clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- start  in  1  one-cycle pulse; launches the root
- arrowHit  in  1  level; arrow overlaps a bubble-coloured pixel
- slotDrawReq  in  N  per-slot drawingRequest from the bubble instances
- slotRGB  in  N*8  per-slot RGB; slot i occupies bits [8i+7:8i]
- spawn  out  N  one-cycle start pulse per slot
- hit  out  N  one-cycle Hit pulse per slot
- alive  out  N  slot currently active
- drawingRequest  out  1  an alive slot is drawing at this pixel
- RGBout  out  8  pixel of the selected slot
- remaining  out  6  pops still required to win
- score  out  SCORE_W  accumulated score
- win  out  1  all N bubbles popped

Behaviour:
- Reset values: spawn=0, hit=0, alive=0, remaining=N, score=0, win=0, FSM=IDLE, holdoff counter=0.
- Slot level: L(i) = floor(log2(i+1)). Leaves are slots with L = LEVELS-1.
- FSM states: IDLE, ARMED, LOCKOUT, WON.
- IDLE:
  - start=1 -> next cycle spawn[0]=1 and alive[0]=1; go to ARMED.
  - arrowHit is ignored.
- ARMED, hit selection:
  - On a cycle where arrowHit=1, let k be the lowest index with alive[k] & slotDrawReq[k].
  - If k exists, the next cycle has all of: hit[k]=1, alive[k]=0, score+=SCORE_BASE<<L(k), remaining-=1.
  - If k is not a leaf, the same cycle also has spawn[2k+1]=spawn[2k+2]=1 and both children alive.
  - Then go to LOCKOUT and load the holdoff counter with HOLDOFF_FRAMES.
  - If no such k exists, there is no effect and the FSM stays in ARMED.
- LOCKOUT:
  - The counter decrements on each startOfFrame, saturating at 0.
  - Return to ARMED when counter=0 and arrowHit=0. Both conditions are required, so one arrow contact never pops twice.
  - No hits are accepted in LOCKOUT.
- Win:
  - When remaining reaches 0, win=1 in the same cycle remaining shows 0, and the FSM goes to WON.
  - WON holds win=1 and alive=0.
- Restart:
  - start in WON clears score, resets remaining=N, spawns the root and goes to ARMED.
  - start in ARMED or LOCKOUT is ignored.
- Hit and spawn are registered. Latency from an arrowHit sample to hit/spawn/alive/score update is exactly 1 cycle.
- A slot that is both hit and spawning in the same cycle cannot occur, because children are never alive before their parent pops.
- Pixel mux (combinational):
  - drawingRequest = OR over i of (alive[i] & slotDrawReq[i]).
  - RGBout = slotRGB of the lowest-index alive drawing slot, else TRANSPARENT.
  - slotDrawReq from dead slots is ignored for both the mux and hit selection.
- score saturates at 2**SCORE_W-1 and does not wrap.
- Asynchronous reset mid-operation clears all state immediately; spawn and hit drop within the reset.

Test Plan:
- Reset, then start pulse -> spawn=...001 for 1 cycle and alive[0]=1. Then arrowHit with slotDrawReq[0]=1 -> next cycle hit[0]=1, spawn[1]=spawn[2]=1, alive=3'b110, score=10, remaining=6 (LEVELS=3).
- arrowHit held high for 10 frames over slot 1 -> exactly one hit[1] pulse. A second hit is accepted only after arrowHit falls and at least 2 startOfFrame pulses have occurred.
- Simultaneous slotDrawReq[1] and slotDrawReq[2] with arrowHit -> only hit[1]. RGBout equals slotRGB[15:8].
- arrowHit with slotDrawReq set only on dead slot 5 -> no hit, score unchanged, drawingRequest=0, RGBout=8'hFF.
- Pop all 7 slots in order -> score=10+2*20+4*40=210, remaining=0, win=1. Then start -> score=0, remaining=7, alive[0]=1, win=0.
- Assert resetN low during LOCKOUT -> all outputs return to reset values asynchronously. After release, a start pulse is required before any hit is accepted.
